// File: rtl/riscv_div_pkg.sv
// rtl/riscv_div_pkg.sv - shared types and helpers for the iterative RV32M divider
package riscv_div_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic is_signed(input div_op_e op);
    return !op[0];
  endfunction

  function automatic logic is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial-subtract the divisor
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // one extra bit so the shifted partial remainder never overflows the trial subtract
  assign shifted = {rem_in, dvd_msb};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = !diff[XLEN];
  assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle
// Optional: define DIV_EARLY_OUT_EN to skip iteration for divide-by-zero, overflow and |a|<|b|.
module iter_divider
  import riscv_div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state, state_next;
  div_op_e         op_in, op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] quo, rem, dvs;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r, div0, ovf;

  logic            accept, sgn, a_neg, b_neg, in_div0, in_ovf, early;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [XLEN-1:0] q_res, r_res;

  assign op_in   = div_op_e'(op);
  assign accept  = start && (state != CALC) && !kill;
  assign sgn     = is_signed(op_in);
  assign a_neg   = sgn && op_a[XLEN-1];
  assign b_neg   = sgn && op_b[XLEN-1];
  assign abs_a   = a_neg ? -op_a : op_a;
  assign abs_b   = b_neg ? -op_b : op_b;
  assign in_div0 = (op_b == '0);
  assign in_ovf  = sgn && (op_a == MIN_VAL) && (op_b == '1);

`ifdef DIV_EARLY_OUT_EN
  assign early = in_div0 || in_ovf || (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem),
    .dvd_msb (quo[XLEN-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = early ? DONE : CALC;
      CALC: begin
        if (kill)          state_next = IDLE;
        else if (cnt == 1) state_next = DONE;
      end
      DONE:    state_next = accept ? (early ? DONE : CALC) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // quo doubles as the dividend shift register; quotient bits enter at the bottom
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_DIV;
      rd_q  <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_q  <= op_in;
      rd_q  <= rd_in;
      dvs   <= abs_b;
      cnt   <= CW'(XLEN);
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      div0  <= in_div0;
      ovf   <= in_ovf;
      if (early) begin
        quo <= '0;
        rem <= abs_a;
      end else begin
        quo <= abs_a;
        rem <= '0;
      end
    end else if (state == CALC && !kill) begin
      rem <= step_rem;
      quo <= {quo[XLEN-2:0], step_q};
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    busy  = (state == CALC);
    done  = (state == DONE);
    q_res = neg_q ? -quo : quo;
    r_res = neg_r ? -rem : rem;
    // with a zero divisor rem already holds |a|, so only the quotient needs overriding
    if (div0) q_res = '1;
    if (ovf) begin
      q_res = MIN_VAL;
      r_res = '0;
    end
    wb_data = is_rem(op_q) ? r_res : q_res;
    wb_rd   = rd_q;
    wb_we   = done && (rd_q != 5'd0);
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - self-checking bench for iter_divider (table vectors plus multi-cycle sequences)
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [1:0]  op;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  iter_divider dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .kill(kill), .busy(busy), .done(done), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_we(wb_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (!o[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    logic skip;
    ma = (!o[0] && a[31]) ? (~a + 32'd1) : a;
    mb = (!o[0] && b[31]) ? (~b + 32'd1) : b;
    skip = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
    return (EARLY && skip) ? 1 : 33;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input string name);
    int cyc;
    logic overlap;
    overlap = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (busy && done) overlap = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (busy && done) overlap = 1'b1;
    check({name, " latency"}, cyc, ref_lat(o, a, b));
    check({name, " data"}, wb_data, exp);
    check({name, " wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check({name, " wb_we"}, {31'd0, wb_we}, {31'd0, rd != 5'd0});
    check({name, " busy&done"}, {31'd0, overlap}, 32'd0);
  endtask

  logic [31:0] vals[6];
  logic        flag;
  int          cyc;

  initial begin
    vt[0]  = '{2'b01, 32'd100,        32'd7,          5'd1,  32'd14};
    vt[1]  = '{2'b11, 32'd100,        32'd7,          5'd2,  32'd2};
    vt[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD};
    vt[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF};
    vt[4]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  5'd5,  32'hFFFF_FFFD};
    vt[5]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd6,  32'd1};
    vt[6]  = '{2'b00, 32'd5,          32'd0,          5'd7,  32'hFFFF_FFFF};
    vt[7]  = '{2'b11, 32'd5,          32'd0,          5'd8,  32'd5};
    vt[8]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000};
    vt[9]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0};
    vt[10] = '{2'b01, 32'd100,        32'd7,          5'd0,  32'd14};
    vt[11] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          5'd11, 32'hFFFF_FFFB};
    vt[12] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF};

    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset wb_we", {31'd0, wb_we}, 32'd0);
    check("reset wb_rd", {27'd0, wb_rd}, 32'd0);
    check("reset wb_data", wb_data, 32'd0);

    for (int i = 0; i < 13; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].rd, vt[i].exp, $sformatf("vec%0d", i));

    // start held from mid-CALC through the DONE cycle: ignored, then accepted back-to-back
    @(negedge clk);
    start = 1'b1; op = 2'b01; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    flag = 1'b0;
    for (int k = 1; k < 33; k++) begin
      if (done || !busy) flag = 1'b1;
      if (k == 10) begin
        start = 1'b1; op = 2'b01; op_a = 32'd200; op_b = 32'd9; rd_in = 5'd5;
      end
      @(negedge clk);
    end
    check("b2b calc window", {31'd0, flag}, 32'd0);
    check("b2b first done", {31'd0, done}, 32'd1);
    check("b2b first data", wb_data, 32'd14);
    check("b2b first rd", {27'd0, wb_rd}, 32'd3);
    @(negedge clk);
    start = 1'b0;
    check("b2b second busy", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b second latency", cyc, 33);
    check("b2b second data", wb_data, 32'd22);
    check("b2b second rd", {27'd0, wb_rd}, 32'd5);

    // kill at cycle 10 with start asserted: kill wins
    @(negedge clk);
    start = 1'b1; op = 2'b01; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1; start = 1'b1;
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    check("kill busy", {31'd0, busy}, 32'd0);
    check("kill done", {31'd0, done}, 32'd0);
    flag = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) flag = 1'b1;
    end
    check("kill no done", {31'd0, flag}, 32'd0);

    // reset at cycle 20
    @(negedge clk);
    start = 1'b1; op = 2'b00; op_a = 32'hFFFF_FFF9; op_b = 32'd2; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst wb_we", {31'd0, wb_we}, 32'd0);
    check("rst wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    flag = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) flag = 1'b1;
    end
    check("rst no done", {31'd0, flag}, 32'd0);

    // kill arriving during DONE does not cancel the result already presented
    @(negedge clk);
    start = 1'b1; op = 2'b01; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    kill = 1'b1;
    #1;
    check("kill@done done", {31'd0, done}, 32'd1);
    check("kill@done wb_we", {31'd0, wb_we}, 32'd1);
    check("kill@done data", wb_data, 32'd14);
    @(negedge clk);
    kill = 1'b0;
    check("kill@done after", {31'd0, done}, 32'd0);

    vals[0] = 32'd0; vals[1] = 32'd1; vals[2] = 32'hFFFF_FFFF;
    vals[3] = 32'h8000_0000; vals[4] = 32'h7FFF_FFFF; vals[5] = 32'hFFFF_FF9C;
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          run_op(2'(o), vals[i], vals[j], 5'd12, ref_res(2'(o), vals[i], vals[j]),
                 $sformatf("edge op%0d %h/%h", o, vals[i], vals[j]));

    for (int n = 0; n < 16; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (n < 8) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      run_op(ro, ra, rb, 5'd13, ref_res(ro, ra, rb), $sformatf("rand op%0d %h/%h", ro, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
